// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order dual-issue scheduler with scoreboard; ports: clk, reset, instr1_in/instr2_in, flush, issue_ready, wb_valid/wb_rd in; issue0/1_valid/instr, fetch_stall, halted out
module issue_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr1_in,
  input  logic [15:0] instr2_in,
  input  logic        flush,
  input  logic        issue_ready,
  input  logic        wb_valid,
  input  logic [2:0]  wb_rd,
  output logic        issue0_valid,
  output logic        issue1_valid,
  output logic [15:0] issue0_instr,
  output logic [15:0] issue1_instr,
  output logic        fetch_stall,
  output logic        halted
);
  typedef enum logic [1:0] {EMPTY, PAIR, B_ONLY, HALTED} state_t;
  state_t state, state_nx;
  logic [15:0] a, b;
  logic a_v, b_v;
  logic [7:0] pend, clr, pe, set;
  logic a_iss, b_co, b_solo, halt_iss, load;

  function automatic logic wr(input logic [15:0] i);
    return i[15:12] >= 4'h1 && i[15:12] <= 4'hC && i[11:9] != 3'd0;
  endfunction

  function automatic logic rd1(input logic [15:0] i);
    return i[15:12] >= 4'h1 && i[15:12] <= 4'hE;
  endfunction

  function automatic logic rd2(input logic [15:0] i);
    return (i[15:12] >= 4'h1 && i[15:12] <= 4'h7) || i[15:12] == 4'hD || i[15:12] == 4'hE;
  endfunction

  function automatic logic elig(input logic [15:0] i, input logic [7:0] p);
    return !(rd1(i) && p[i[8:6]]) && !(rd2(i) && p[i[5:3]]);
  endfunction

  function automatic logic dep(input logic [15:0] y, input logic [15:0] o);
    return wr(o) && ((rd1(y) && y[8:6] == o[11:9]) || (rd2(y) && y[5:3] == o[11:9]) ||
                     (wr(y) && y[11:9] == o[11:9]));
  endfunction

  // same-cycle write-back already counts as not pending; r0 is never pending
  assign clr = wb_valid ? 8'd1 << wb_rd : 8'd0;
  assign pe  = pend & ~clr & 8'hFE;

  always_ff @(posedge clk)
    if (reset) state <= EMPTY;
    else state <= state_nx;

  always_comb begin
    load     = state != HALTED && !flush && !halt_iss && !fetch_stall;
    state_nx = state == HALTED ? HALTED :
               flush ? EMPTY :
               halt_iss ? HALTED :
               load ? ((|{instr1_in, instr2_in}) ? PAIR : EMPTY) :
               (state == PAIR && a_iss) ? B_ONLY : state;
  end

  // a halt travelling in B is kept off slot1 so it always retires from slot0
  always_comb begin
    a_iss        = state == PAIR && issue_ready && !flush && a_v && elig(a, pe);
    b_co         = a_iss && b_v && elig(b, pe) && !dep(b, a) && a[15:12] < 4'hE && b[15:12] != 4'hF;
    b_solo       = state == B_ONLY && issue_ready && !flush && elig(b, pe);
    halt_iss     = (a_iss && a[15:12] == 4'hF) || (b_solo && b[15:12] == 4'hF);
    fetch_stall  = state == HALTED ? 1'b1 :
                   (flush || state == EMPTY) ? 1'b0 :
                   state == PAIR ? (!a_iss || (b_v && !b_co) || halt_iss) :
                   (!b_solo || halt_iss);
    issue0_valid = a_iss || b_solo;
    issue0_instr = state == B_ONLY ? b : a;
    issue1_valid = b_co;
    issue1_instr = b;
    halted       = state == HALTED;
    set          = ((a_iss && wr(a)) ? 8'd1 << a[11:9] : 8'd0) |
                   (((b_co || b_solo) && wr(b)) ? 8'd1 << b[11:9] : 8'd0);
  end

  // a lone younger word is promoted into A so slot0 always carries the oldest work
  always_ff @(posedge clk)
    if (reset) begin
      a    <= '0;
      b    <= '0;
      a_v  <= 1'b0;
      b_v  <= 1'b0;
      pend <= '0;
    end else begin
      pend <= ((pend & ~clr) | set) & 8'hFE;
      if (flush && state != HALTED) begin
        a_v <= 1'b0;
        b_v <= 1'b0;
      end else if (load) begin
        a   <= instr1_in != 16'h0 ? instr1_in : instr2_in;
        a_v <= |{instr1_in, instr2_in};
        b   <= instr2_in;
        b_v <= instr1_in != 16'h0 && instr2_in != 16'h0;
      end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: scoreboard-driven bench for issue_scheduler
module tb_issue_scheduler;
  logic clk = 0, reset = 1, flush = 0, issue_ready = 1, wb_valid = 0;
  logic [15:0] instr1_in = 0, instr2_in = 0;
  logic [2:0] wb_rd = 0;
  logic issue0_valid, issue1_valid, fetch_stall, halted;
  logic [15:0] issue0_instr, issue1_instr;
  int n_cmp = 0, n_bad = 0;

  typedef struct { logic slot; logic [15:0] instr; } exp_t;
  exp_t q[$];
  exp_t e;

  issue_scheduler dut (
    .clk(clk), .reset(reset), .instr1_in(instr1_in), .instr2_in(instr2_in),
    .flush(flush), .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue0_valid(issue0_valid), .issue1_valid(issue1_valid),
    .issue0_instr(issue0_instr), .issue1_instr(issue1_instr),
    .fetch_stall(fetch_stall), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset) begin
    if (issue0_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++; $display("FAIL slot0_unexpected got=%h exp=none", issue0_instr);
      end else begin
        e = q.pop_front();
        if (e.slot !== 1'b0 || e.instr !== issue0_instr) begin
          n_bad++; $display("FAIL slot0_issue got=%h exp=%h on slot%0d", issue0_instr, e.instr, e.slot);
        end
      end
    end
    if (issue1_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++; $display("FAIL slot1_unexpected got=%h exp=none", issue1_instr);
      end else begin
        e = q.pop_front();
        if (e.slot !== 1'b1 || e.instr !== issue1_instr) begin
          n_bad++; $display("FAIL slot1_issue got=%h exp=%h on slot%0d", issue1_instr, e.instr, e.slot);
        end
      end
    end
  end

  task cyc(); @(posedge clk); #1; endtask
  task smp(); @(negedge clk); endtask

  task apply_reset();
    cyc(); reset = 1; flush = 0; issue_ready = 1; wb_valid = 0; wb_rd = 0; instr1_in = 0; instr2_in = 0;
    cyc(); cyc(); reset = 0;
  endtask

  task test_reset();
    apply_reset(); smp();
    n_cmp++; if (issue0_valid !== 0 || issue1_valid !== 0) begin n_bad++; $display("FAIL rst_valids got=%b%b exp=00", issue0_valid, issue1_valid); end
    n_cmp++; if (fetch_stall !== 0) begin n_bad++; $display("FAIL rst_stall got=%b exp=0", fetch_stall); end
    n_cmp++; if (halted !== 0) begin n_bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    n_cmp++; if (dut.pend !== 8'h00) begin n_bad++; $display("FAIL rst_pend got=%h exp=00", dut.pend); end
    cyc(); issue_ready = 0; instr1_in = 16'h1298; instr2_in = 16'h1970;
    cyc(); instr1_in = 0; instr2_in = 0; smp();
    n_cmp++; if (fetch_stall !== 1) begin n_bad++; $display("FAIL rst_midpair_stall got=%b exp=1", fetch_stall); end
    apply_reset();
    repeat (3) begin
      smp();
      n_cmp++; if (issue0_valid !== 0 || fetch_stall !== 0) begin n_bad++; $display("FAIL rst_midpair_clear got=%b/%b exp=0/0", issue0_valid, fetch_stall); end
    end
  endtask

  task test_coissue();
    apply_reset();
    instr1_in = 16'h1298; instr2_in = 16'h1970; q.push_back('{1'b0, 16'h1298}); q.push_back('{1'b1, 16'h1970});
    cyc(); instr1_in = 0; instr2_in = 0; smp();
    n_cmp++; if (issue1_valid !== 1) begin n_bad++; $display("FAIL co_slot1 got=%b exp=1", issue1_valid); end
    n_cmp++; if (fetch_stall !== 0) begin n_bad++; $display("FAIL co_stall got=%b exp=0", fetch_stall); end
    cyc(); smp();
    n_cmp++; if (dut.pend !== 8'h12) begin n_bad++; $display("FAIL co_pend got=%h exp=12", dut.pend); end
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL co_drain got=%0d exp=0", q.size()); end
  endtask

  task test_raw();
    apply_reset();
    instr1_in = 16'h1298; instr2_in = 16'h1868; q.push_back('{1'b0, 16'h1298});
    cyc(); instr1_in = 0; instr2_in = 0; smp();
    n_cmp++; if (issue1_valid !== 0 || fetch_stall !== 1) begin n_bad++; $display("FAIL raw_c1 got=%b/%b exp=0/1", issue1_valid, fetch_stall); end
    cyc(); smp();
    n_cmp++; if (issue0_valid !== 0 || fetch_stall !== 1) begin n_bad++; $display("FAIL raw_wait got=%b/%b exp=0/1", issue0_valid, fetch_stall); end
    cyc(); wb_valid = 1; wb_rd = 1; q.push_back('{1'b0, 16'h1868}); smp();
    n_cmp++; if (issue0_valid !== 1 || fetch_stall !== 0) begin n_bad++; $display("FAIL raw_bypass got=%b/%b exp=1/0", issue0_valid, fetch_stall); end
    cyc(); wb_valid = 0; smp();
    n_cmp++; if (dut.pend !== 8'h10) begin n_bad++; $display("FAIL raw_pend got=%h exp=10", dut.pend); end
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL raw_drain got=%0d exp=0", q.size()); end
  endtask

  task test_branch();
    apply_reset();
    instr1_in = 16'hE050; instr2_in = 16'h1970; q.push_back('{1'b0, 16'hE050});
    cyc(); instr1_in = 0; instr2_in = 0; smp();
    n_cmp++; if (issue1_valid !== 0 || fetch_stall !== 1) begin n_bad++; $display("FAIL br_alone got=%b/%b exp=0/1", issue1_valid, fetch_stall); end
    cyc(); flush = 1; instr1_in = 16'h1970; instr2_in = 16'h1298; smp();
    n_cmp++; if (issue0_valid !== 0 || fetch_stall !== 0) begin n_bad++; $display("FAIL br_flush got=%b/%b exp=0/0", issue0_valid, fetch_stall); end
    cyc(); flush = 0; instr1_in = 0; instr2_in = 0;
    repeat (3) begin
      smp();
      n_cmp++; if (issue0_valid !== 0 || fetch_stall !== 0) begin n_bad++; $display("FAIL br_empty got=%b/%b exp=0/0", issue0_valid, fetch_stall); end
    end
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL br_drain got=%0d exp=0", q.size()); end
  endtask

  task test_halt();
    apply_reset();
    instr1_in = 16'hF000; instr2_in = 16'h1970; q.push_back('{1'b0, 16'hF000});
    cyc(); instr1_in = 0; instr2_in = 0; smp();
    n_cmp++; if (issue1_valid !== 0 || fetch_stall !== 1 || halted !== 0) begin n_bad++; $display("FAIL halt_issue got=%b/%b/%b exp=0/1/0", issue1_valid, fetch_stall, halted); end
    cyc(); flush = 1; smp();
    n_cmp++; if (halted !== 1 || fetch_stall !== 1 || issue0_valid !== 0) begin n_bad++; $display("FAIL halt_flush got=%b/%b/%b exp=1/1/0", halted, fetch_stall, issue0_valid); end
    cyc(); flush = 0; instr1_in = 16'h1298;
    repeat (3) begin
      smp();
      n_cmp++; if (halted !== 1 || fetch_stall !== 1) begin n_bad++; $display("FAIL halt_hold got=%b/%b exp=1/1", halted, fetch_stall); end
    end
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL halt_drain got=%0d exp=0", q.size()); end
    apply_reset(); smp();
    n_cmp++; if (halted !== 0 || fetch_stall !== 0) begin n_bad++; $display("FAIL halt_reset got=%b/%b exp=0/0", halted, fetch_stall); end
  endtask

  task test_backpressure();
    apply_reset();
    issue_ready = 0; instr1_in = 16'h1298; instr2_in = 16'h1970;
    q.push_back('{1'b0, 16'h1298}); q.push_back('{1'b1, 16'h1970});
    cyc(); instr1_in = 0; instr2_in = 0;
    repeat (3) begin
      smp();
      n_cmp++; if (issue0_valid !== 0 || issue1_valid !== 0 || fetch_stall !== 1) begin n_bad++; $display("FAIL bp_hold got=%b%b/%b exp=00/1", issue0_valid, issue1_valid, fetch_stall); end
    end
    cyc(); issue_ready = 1; smp();
    n_cmp++; if (issue1_valid !== 1 || fetch_stall !== 0) begin n_bad++; $display("FAIL bp_release got=%b/%b exp=1/0", issue1_valid, fetch_stall); end
    cyc(); smp();
    n_cmp++; if (dut.pend !== 8'h12) begin n_bad++; $display("FAIL bp_pend got=%h exp=12", dut.pend); end
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL bp_drain got=%0d exp=0", q.size()); end
  endtask

  task test_collision();
    apply_reset();
    instr1_in = 16'h1298; instr2_in = 0; q.push_back('{1'b0, 16'h1298});
    cyc(); instr1_in = 0; wb_valid = 1; wb_rd = 1; smp();
    n_cmp++; if (issue0_valid !== 1 || fetch_stall !== 0) begin n_bad++; $display("FAIL col_issue got=%b/%b exp=1/0", issue0_valid, fetch_stall); end
    cyc(); wb_valid = 0; smp();
    n_cmp++; if (dut.pend !== 8'h02) begin n_bad++; $display("FAIL col_pend got=%h exp=02", dut.pend); end
  endtask

  task test_r0();
    apply_reset();
    instr1_in = 16'h1000; instr2_in = 16'h1000; q.push_back('{1'b0, 16'h1000}); q.push_back('{1'b1, 16'h1000});
    cyc(); instr1_in = 0; instr2_in = 0; smp();
    n_cmp++; if (issue1_valid !== 1) begin n_bad++; $display("FAIL r0_coissue got=%b exp=1", issue1_valid); end
    cyc(); smp();
    n_cmp++; if (dut.pend !== 8'h00) begin n_bad++; $display("FAIL r0_pend got=%h exp=00", dut.pend); end
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL r0_drain got=%0d exp=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_coissue();
    test_raw();
    test_branch();
    test_halt();
    test_backpressure();
    test_collision();
    test_r0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
